// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard detection unit.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hazardState_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/md_busy_counter.sv
// Down-counter tracking the remaining freeze cycles of a multi-cycle mult/div in EX.
module md_busy_counter #(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned CNT_W    = $clog2(MD_LATENCY) + 1;
    localparam int unsigned LOAD_VAL = (MD_LATENCY > 1) ? MD_LATENCY - 2 : 0;

    logic [CNT_W-1:0] mdCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdCnt <= '0;
        end else if (load) begin
            mdCnt <= CNT_W'(LOAD_VAL);
        end else if (dec && (mdCnt != '0)) begin
            mdCnt <= mdCnt - CNT_W'(1);
        end
    end

    assign zero = (mdCnt == '0);

endmodule

// File: rtl/hazard_detect_unit.sv
// Stall/flush controller: load-use bubble, mult/div freeze, taken-branch flush.
// Optional stall statistics output enabled by defining HAZARD_STATS_EN.
module hazard_detect_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_RegisterRs,
    input  logic [4:0] IFID_RegisterRt,
    input  logic       IFID_UsesRt,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_RegisterRt,
    input  logic       IDEX_MultDiv,
    input  logic       EX_BranchTaken,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEXWrite,
    output logic       IDEX_Bubble,
    output logic       IFID_Flush,
    output logic       EXMEM_Bubble,
    output logic       MD_Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [STATS_W-1:0] StallCycles
`endif
);

    hazardState_t state;
    logic         loadUse;
    logic         mdStart;
    logic         mdDec;
    logic         mdZero;

    md_busy_counter #(
        .MD_LATENCY(MD_LATENCY)
    ) uMdCnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (mdStart),
        .dec  (mdDec),
        .zero (mdZero)
    );

    assign loadUse = IDEX_MemRead && (IDEX_RegisterRt != REG_ZERO) &&
                     ((IDEX_RegisterRt == IFID_RegisterRs) ||
                      (IFID_UsesRt && (IDEX_RegisterRt == IFID_RegisterRt)));

    // Outputs are forced to their defaults while reset is held, regardless of inputs.
    always_comb begin
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        IDEX_Bubble  = 1'b0;
        IFID_Flush   = 1'b0;
        EXMEM_Bubble = 1'b0;
        mdStart      = 1'b0;
        mdDec        = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IFID_Flush  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (IDEX_MultDiv && (MD_LATENCY > 1)) begin
                        PCWrite      = 1'b0;
                        IFIDWrite    = 1'b0;
                        IDEXWrite    = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        mdStart      = 1'b1;
                    end else if (loadUse) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (!mdZero) begin
                        PCWrite      = 1'b0;
                        IFIDWrite    = 1'b0;
                        IDEXWrite    = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        mdDec        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:     if (mdStart) state <= MD_BUSY;
                MD_BUSY: if (mdZero)  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign MD_Busy = (state != RUN);

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
        end else if (!PCWrite && (StallCycles != '1)) begin
            StallCycles <= StallCycles + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed self-checking bench for hazard_detect_unit with an expected-output scoreboard queue.
module tb_hazard_detect_unit;

    // Expected vector: {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble, IFID_Flush, EXMEM_Bubble, MD_Busy}
    localparam logic [6:0] DEF  = 7'b1110000;
    localparam logic [6:0] LU   = 7'b0011000;
    localparam logic [6:0] FRZ0 = 7'b0000010;
    localparam logic [6:0] FRZB = 7'b0000011;
    localparam logic [6:0] REL  = 7'b1110001;
    localparam logic [6:0] BR   = 7'b1111100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IFID_RegisterRs;
    logic [4:0] IFID_RegisterRt;
    logic       IFID_UsesRt;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_RegisterRt;
    logic       IDEX_MultDiv;
    logic       EX_BranchTaken;
    logic       PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble, IFID_Flush, EXMEM_Bubble, MD_Busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCycles;
    int unsigned expStalls = 0;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } sbEntry_t;
    sbEntry_t sb[$];

    always #5 clk = ~clk;

    hazard_detect_unit #(
        .MD_LATENCY(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IFID_RegisterRs(IFID_RegisterRs),
        .IFID_RegisterRt(IFID_RegisterRt),
        .IFID_UsesRt    (IFID_UsesRt),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_RegisterRt(IDEX_RegisterRt),
        .IDEX_MultDiv   (IDEX_MultDiv),
        .EX_BranchTaken (EX_BranchTaken),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IDEXWrite      (IDEXWrite),
        .IDEX_Bubble    (IDEX_Bubble),
        .IFID_Flush     (IFID_Flush),
        .EXMEM_Bubble   (EXMEM_Bubble),
        .MD_Busy        (MD_Busy)
`ifdef HAZARD_STATS_EN
        ,
        .StallCycles    (StallCycles)
`endif
    );

    task automatic setIn(input logic memRead, input logic [4:0] exRt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic usesRt, input logic md, input logic br);
        IDEX_MemRead    = memRead;
        IDEX_RegisterRt = exRt;
        IFID_RegisterRs = rs;
        IFID_RegisterRt = rt;
        IFID_UsesRt     = usesRt;
        IDEX_MultDiv    = md;
        EX_BranchTaken  = br;
    endtask

    // Inputs are already applied; check at the falling edge, then advance past the rising edge.
    task automatic step(input string tag, input logic [6:0] exp);
        sbEntry_t e;
        logic [6:0] obs;
        sb.push_back('{tag, exp});
        @(negedge clk);
        e   = sb.pop_front();
        obs = {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble, IFID_Flush, EXMEM_Bubble, MD_Busy};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
        end
        @(posedge clk);
`ifdef HAZARD_STATS_EN
        if (!rst_n) expStalls = 0;
        else if (!e.exp[6]) expStalls++;
`endif
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
        #2;
        step("reset_hold", DEF);
        rst_n = 1'b1;
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("idle", DEF);

        setIn(1'b1, 5'd8, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
        step("lu_rs", LU);
        setIn(1'b0, 5'd8, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
        step("lu_after", DEF);
        setIn(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("lu_r0", DEF);
        setIn(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
        step("lu_rt_unused", DEF);
        setIn(1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
        step("lu_rt_used", LU);
        setIn(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b1);
        step("branch_over_lu", BR);

        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("md_start", FRZ0);
        setIn(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
        step("md_busy_ignore_br", FRZB);
        step("md_busy2", FRZB);
        step("md_release", REL);
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("md_run", DEF);

        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("b2b_start1", FRZ0);
        step("b2b_busy1a", FRZB);
        step("b2b_busy1b", FRZB);
        step("b2b_rel1", REL);
        step("b2b_start2", FRZ0);
        step("b2b_busy2a", FRZB);
        step("b2b_busy2b", FRZB);
        step("b2b_rel2", REL);
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("b2b_run", DEF);

        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("rst_seq_start", FRZ0);
        step("rst_seq_busy", FRZB);
        rst_n = 1'b0;
        step("rst_mid_seq", DEF);
        rst_n = 1'b1;
        step("restart_start", FRZ0);
        step("restart_busy_a", FRZB);
        step("restart_busy_b", FRZB);
        step("restart_rel", REL);
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("restart_run", DEF);

`ifdef HAZARD_STATS_EN
        checks++;
        assert (StallCycles === 32'(expStalls)) else begin
            errors++;
            $error("FAIL stall_count: observed=%0d expected=%0d", StallCycles, expStalls);
        end
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
